dmem_req_unit: RTL and testbench

Data-memory request unit between the execute stage and the memory stage of the 5-stage RV32I pipeline. It accepts one load or store from execute and computes the word-aligned address, byte masks and lane-shifted store data. It issues a single-cycle request to the data memory and waits for `dmem_resp`. It then presents the response to the memory stage, holding it while downstream is stalled, and drops it if the pipeline is flushed mid-flight.

---
 rtl/dmem_req_if.sv | 43 ++++
 rtl/dmem_req_unit.sv | 166 ++++++++++++++++
 tb/tb_dmem_req_unit.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_req_if.sv
// Bus bundle between the execute stage, the data memory and the memory stage.
//
// Handshake: an op transfers from execute on a cycle where ex_valid and
// ex_ready are both high and flush is low. A response transfers to the memory
// stage on a cycle where rsp_valid is high and mem_stall is low; while
// mem_stall is high, rsp_valid and the response fields are held unchanged.
interface dmem_req_if;
    logic        ex_valid;
    logic        ex_is_store;
    logic [2:0]  ex_funct3;
    logic [31:0] ex_addr;
    logic [31:0] ex_wdata;
    logic        ex_ready;
    logic        flush;
    logic        mem_stall;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_rmask;
    logic [3:0]  dmem_wmask;
    logic [31:0] dmem_wdata;
    logic        dmem_resp;
    logic [31:0] dmem_rdata;
    logic        rsp_valid;
    logic        rsp_is_load;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_shift;
    logic        bad_req;

    // The request unit itself.
    modport slave (
        input  ex_valid, ex_is_store, ex_funct3, ex_addr, ex_wdata,
        input  flush, mem_stall, dmem_resp, dmem_rdata,
        output ex_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        output rsp_valid, rsp_is_load, rsp_rdata, rsp_shift, bad_req
    );

    // The surrounding pipeline and memory.
    modport master (
        output ex_valid, ex_is_store, ex_funct3, ex_addr, ex_wdata,
        output flush, mem_stall, dmem_resp, dmem_rdata,
        input  ex_ready, dmem_addr, dmem_rmask, dmem_wmask, dmem_wdata,
        input  rsp_valid, rsp_is_load, rsp_rdata, rsp_shift, bad_req
    );
endinterface

// File: rtl/dmem_req_unit.sv
// Data-memory request unit: accepts one RV32I load/store from execute,
// issues a single-cycle masked request, waits for the memory response and
// presents it to the memory stage. One op in flight at a time.
module dmem_req_unit (
    input  logic       clk,
    input  logic       rst,
    dmem_req_if.slave  bus,
    output logic [1:0] dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state_q;
    logic        drop_q;
    logic [31:0] addr_q;
    logic [3:0]  rmask_q;
    logic [3:0]  wmask_q;
    logic [31:0] wdata_q;
    logic        is_load_q;
    logic [1:0]  shift_q;
    logic [31:0] hold_q;

    logic        legal_f3_d;
    logic        aligned_d;
    logic        ok_d;
    logic        accept_d;
    logic [3:0]  mask_d;
    logic [31:0] wdata_d;
    logic        wait_hit_d;
    logic        hold_out_d;

    // Decode the op presented by execute: legality, alignment, lane mask and
    // replicated store data (replication puts the value on every lane, so the
    // mask alone selects the right bytes).
    always_comb begin
        legal_f3_d = 1'b0;
        aligned_d  = 1'b0;
        mask_d     = 4'b0000;
        wdata_d    = 32'h0;
        if (bus.ex_is_store) begin
            legal_f3_d = (bus.ex_funct3 == 3'd0) || (bus.ex_funct3 == 3'd1) ||
                         (bus.ex_funct3 == 3'd2);
        end else begin
            legal_f3_d = (bus.ex_funct3 == 3'd0) || (bus.ex_funct3 == 3'd1) ||
                         (bus.ex_funct3 == 3'd2) || (bus.ex_funct3 == 3'd4) ||
                         (bus.ex_funct3 == 3'd5);
        end
        case (bus.ex_funct3[1:0])
            2'b00: begin
                aligned_d = 1'b1;
                mask_d    = 4'b0001 << bus.ex_addr[1:0];
                wdata_d   = {4{bus.ex_wdata[7:0]}};
            end
            2'b01: begin
                aligned_d = ~bus.ex_addr[0];
                mask_d    = 4'b0011 << bus.ex_addr[1:0];
                wdata_d   = {2{bus.ex_wdata[15:0]}};
            end
            2'b10: begin
                aligned_d = (bus.ex_addr[1:0] == 2'b00);
                mask_d    = 4'b1111;
                wdata_d   = bus.ex_wdata;
            end
            default: begin
                aligned_d = 1'b0;
                mask_d    = 4'b0000;
                wdata_d   = 32'h0;
            end
        endcase
        ok_d       = legal_f3_d & aligned_d;
        accept_d   = (state_q == IDLE) & bus.ex_valid & ~bus.flush;
        // A flush arriving in the same cycle as the response also drops it.
        wait_hit_d = (state_q == WAIT) & bus.dmem_resp & ~drop_q & ~bus.flush;
        hold_out_d = (state_q == HOLD) & ~bus.flush;
    end

    // Request/response FSM with all latched op fields.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            drop_q    <= 1'b0;
            addr_q    <= 32'h0;
            rmask_q   <= 4'b0000;
            wmask_q   <= 4'b0000;
            wdata_q   <= 32'h0;
            is_load_q <= 1'b0;
            shift_q   <= 2'b00;
            hold_q    <= 32'h0;
        end else begin
            case (state_q)
                IDLE: begin
                    drop_q <= 1'b0;
                    if (accept_d && ok_d) begin
                        state_q   <= ISSUE;
                        addr_q    <= {bus.ex_addr[31:2], 2'b00};
                        is_load_q <= ~bus.ex_is_store;
                        shift_q   <= bus.ex_addr[1:0];
                        rmask_q   <= bus.ex_is_store ? 4'b0000 : mask_d;
                        wmask_q   <= bus.ex_is_store ? mask_d : 4'b0000;
                        wdata_q   <= bus.ex_is_store ? wdata_d : 32'h0;
                    end
                end
                ISSUE: begin
                    // Masks live for exactly this one cycle; a response here
                    // cannot belong to this request and is ignored.
                    state_q <= WAIT;
                    rmask_q <= 4'b0000;
                    wmask_q <= 4'b0000;
                    drop_q  <= drop_q | bus.flush;
                end
                WAIT: begin
                    if (bus.dmem_resp) begin
                        wdata_q <= 32'h0;
                        drop_q  <= 1'b0;
                        if (drop_q || bus.flush || !bus.mem_stall) begin
                            state_q <= IDLE;
                        end else begin
                            hold_q  <= bus.dmem_rdata;
                            state_q <= HOLD;
                        end
                    end else begin
                        drop_q <= drop_q | bus.flush;
                    end
                end
                HOLD: begin
                    if (bus.flush || !bus.mem_stall) begin
                        state_q <= IDLE;
                        drop_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    drop_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output drive: request fields come straight from registers; the
    // response path is combinational so an unstalled response is seen in the
    // same cycle as dmem_resp.
    always_comb begin
        bus.ex_ready    = (state_q == IDLE);
        bus.dmem_addr   = addr_q;
        bus.dmem_rmask  = rmask_q;
        bus.dmem_wmask  = wmask_q;
        bus.dmem_wdata  = wdata_q;
        bus.rsp_is_load = is_load_q;
        bus.rsp_shift   = shift_q;
        bus.bad_req     = ~rst & accept_d & ~ok_d;
        bus.rsp_valid   = ~rst & (wait_hit_d | hold_out_d);
        bus.rsp_rdata   = 32'h0;
        if (!rst && wait_hit_d) begin
            bus.rsp_rdata = bus.dmem_rdata;
        end else if (!rst && hold_out_d) begin
            bus.rsp_rdata = hold_q;
        end
        dbg_state_o     = state_q;
    end

endmodule

// File: tb/tb_dmem_req_unit.sv
// Self-checking bench for dmem_req_unit: directed scenarios plus a randomized
// run checked against an arithmetic reference model of the load/store rules.
module tb_dmem_req_unit;

    logic       clk;
    logic       rst;
    logic [1:0] dbg_state;

    dmem_req_if bus ();

    dmem_req_unit dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish, tests=%0d", n_tests);
        $fatal(1, "bench timeout");
    end

    // ---------------- driver tasks ----------------
    // Advance to just after the next rising edge (input drive point).
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.ex_valid    = 1'b0;
        bus.ex_is_store = 1'b0;
        bus.ex_funct3   = 3'd0;
        bus.ex_addr     = 32'h0;
        bus.ex_wdata    = 32'h0;
        bus.flush       = 1'b0;
        bus.mem_stall   = 1'b0;
        bus.dmem_resp   = 1'b0;
        bus.dmem_rdata  = 32'h0;
    endtask

    task automatic drive_op(input logic st, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] wd);
        bus.ex_valid    = 1'b1;
        bus.ex_is_store = st;
        bus.ex_funct3   = f3;
        bus.ex_addr     = a;
        bus.ex_wdata    = wd;
    endtask

    // ---------------- reference model ----------------
    function automatic int m_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    function automatic bit m_legal(input logic st, input logic [2:0] f3,
                                   input logic [31:0] a);
        bit f3_ok;
        if (st) f3_ok = (f3 <= 3'd2);
        else    f3_ok = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
        return f3_ok && ((a % m_size(f3)) == 0);
    endfunction

    function automatic logic [3:0] m_mask(input logic [2:0] f3, input logic [31:0] a);
        int bits;
        bits = ((1 << m_size(f3)) - 1) << (a % 4);
        return bits[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] wd);
        if (m_size(f3) == 1) return (wd & 32'hFF) * 32'h0101_0101;
        if (m_size(f3) == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
        return wd;
    endfunction

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        cyc();
        cyc();
        bus.dmem_resp = 1'b1;
        bus.ex_valid  = 1'b1;
        bus.ex_funct3 = 3'd2;
        bus.ex_addr   = 32'h1;
        @(negedge clk);
        if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ex_ready: got %b want 1", bus.ex_ready); end n_tests++;
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end n_tests++;
        if (bus.bad_req !== 1'b0) begin n_fail++; $display("FAIL reset_bad_req: got %b want 0", bus.bad_req); end n_tests++;
        if ({bus.dmem_rmask, bus.dmem_wmask} !== 8'h00) begin n_fail++; $display("FAIL reset_masks: got %b%b want 0", bus.dmem_rmask, bus.dmem_wmask); end n_tests++;
        if ({bus.dmem_addr, bus.dmem_wdata, bus.rsp_rdata} !== 96'h0) begin n_fail++; $display("FAIL reset_data: addr %h wdata %h rdata %h want 0", bus.dmem_addr, bus.dmem_wdata, bus.rsp_rdata); end n_tests++;
        if ({bus.rsp_shift, bus.rsp_is_load} !== 3'b000) begin n_fail++; $display("FAIL reset_rsp_fields: shift %0d load %b want 0", bus.rsp_shift, bus.rsp_is_load); end n_tests++;
        cyc();
        rst = 1'b0;
        idle_inputs();
        cyc();
    endtask

    task automatic test_load_word();
        drive_op(1'b0, 3'd2, 32'h1000, 32'h0);
        @(negedge clk);
        if (bus.bad_req !== 1'b0) begin n_fail++; $display("FAIL lw_bad_req: got %b want 0", bus.bad_req); end n_tests++;
        cyc();
        bus.ex_valid = 1'b0;
        @(negedge clk);
        if (bus.dmem_rmask !== 4'b1111 || bus.dmem_wmask !== 4'b0000) begin n_fail++; $display("FAIL lw_masks: r %b w %b want 1111/0000", bus.dmem_rmask, bus.dmem_wmask); end n_tests++;
        if (bus.dmem_addr !== 32'h1000) begin n_fail++; $display("FAIL lw_addr: got %h want 00001000", bus.dmem_addr); end n_tests++;
        if (bus.ex_ready !== 1'b0) begin n_fail++; $display("FAIL lw_busy: got %b want 0", bus.ex_ready); end n_tests++;
        cyc();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hDEADBEEF;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hDEADBEEF || bus.rsp_is_load !== 1'b1) begin n_fail++; $display("FAIL lw_rsp: valid %b rdata %h load %b want 1/deadbeef/1", bus.rsp_valid, bus.rsp_rdata, bus.rsp_is_load); end n_tests++;
        if (bus.dmem_rmask !== 4'b0000) begin n_fail++; $display("FAIL lw_wait_mask: got %b want 0000", bus.dmem_rmask); end n_tests++;
        cyc();
        bus.dmem_resp = 1'b0;
        @(negedge clk);
        if (bus.ex_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL lw_done: ready %b valid %b want 1/0", bus.ex_ready, bus.rsp_valid); end n_tests++;
    endtask

    task automatic test_store_byte();
        cyc();
        drive_op(1'b1, 3'd0, 32'h2003, 32'h1234_56AB);
        cyc();
        bus.ex_valid = 1'b0;
        @(negedge clk);
        if (bus.dmem_addr !== 32'h2000 || bus.dmem_wmask !== 4'b1000 || bus.dmem_rmask !== 4'b0000) begin n_fail++; $display("FAIL sb_issue: addr %h w %b r %b want 00002000/1000/0000", bus.dmem_addr, bus.dmem_wmask, bus.dmem_rmask); end n_tests++;
        if (bus.dmem_wdata !== 32'hABABABAB) begin n_fail++; $display("FAIL sb_wdata: got %h want abababab", bus.dmem_wdata); end n_tests++;
        cyc();
        bus.dmem_resp = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b1 || bus.rsp_is_load !== 1'b0) begin n_fail++; $display("FAIL sb_rsp: valid %b load %b want 1/0", bus.rsp_valid, bus.rsp_is_load); end n_tests++;
        cyc();
        bus.dmem_resp = 1'b0;
        @(negedge clk);
        if (bus.dmem_wdata !== 32'h0) begin n_fail++; $display("FAIL sb_wdata_idle: got %h want 0", bus.dmem_wdata); end n_tests++;
    endtask

    task automatic test_stall_hold();
        int valid_cycles;
        cyc();
        drive_op(1'b0, 3'd1, 32'h1006, 32'h0);
        cyc();
        bus.ex_valid = 1'b0;
        cyc();
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'hCAFE_F00D;
        bus.mem_stall  = 1'b1;
        valid_cycles   = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                valid_cycles++;
                if (bus.rsp_rdata !== 32'hCAFE_F00D || bus.rsp_shift !== 2'd2) begin n_fail++; $display("FAIL lh_hold_data: cyc %0d rdata %h shift %0d want cafef00d/2", i, bus.rsp_rdata, bus.rsp_shift); end n_tests++;
            end
            cyc();
            bus.dmem_resp  = 1'b0;
            bus.dmem_rdata = 32'h5555_0000 + i;
            bus.mem_stall  = (i < 2);
        end
        if (valid_cycles !== 4) begin n_fail++; $display("FAIL lh_hold_len: got %0d want 4", valid_cycles); end n_tests++;
        @(negedge clk);
        if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL lh_idle: got %b want 1", bus.ex_ready); end n_tests++;
    endtask

    task automatic test_bad_req();
        cyc();
        drive_op(1'b0, 3'd2, 32'h1002, 32'h0);
        @(negedge clk);
        if (bus.bad_req !== 1'b1 || bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL bad_lw: bad %b ready %b want 1/1", bus.bad_req, bus.ex_ready); end n_tests++;
        cyc();
        drive_op(1'b1, 3'd4, 32'h1000, 32'hFFFF);
        @(negedge clk);
        if (bus.bad_req !== 1'b1 || {bus.dmem_rmask, bus.dmem_wmask} !== 8'h00) begin n_fail++; $display("FAIL bad_sf3: bad %b masks %b%b want 1/0", bus.bad_req, bus.dmem_rmask, bus.dmem_wmask); end n_tests++;
        cyc();
        bus.ex_valid = 1'b0;
        @(negedge clk);
        if (bus.bad_req !== 1'b0 || bus.ex_ready !== 1'b1 || {bus.dmem_rmask, bus.dmem_wmask} !== 8'h00) begin n_fail++; $display("FAIL bad_after: bad %b ready %b masks %b%b want 0/1/0", bus.bad_req, bus.ex_ready, bus.dmem_rmask, bus.dmem_wmask); end n_tests++;
        // A legal op offered together with flush must not be taken.
        cyc();
        drive_op(1'b0, 3'd2, 32'h3000, 32'h0);
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.bad_req !== 1'b0) begin n_fail++; $display("FAIL flush_idle_bad: got %b want 0", bus.bad_req); end n_tests++;
        cyc();
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b0;
        @(negedge clk);
        if (bus.ex_ready !== 1'b1 || bus.dmem_rmask !== 4'b0000) begin n_fail++; $display("FAIL flush_idle: ready %b rmask %b want 1/0000", bus.ex_ready, bus.dmem_rmask); end n_tests++;
    endtask

    task automatic test_flush();
        // Flush while waiting: response is swallowed.
        cyc();
        drive_op(1'b0, 3'd2, 32'h1000, 32'h0);
        cyc();
        bus.ex_valid = 1'b0;
        cyc();
        bus.flush = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flw_flush: valid %b want 0", bus.rsp_valid); end n_tests++;
        cyc();
        bus.flush      = 1'b0;
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h1111_2222;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flw_resp: valid %b want 0", bus.rsp_valid); end n_tests++;
        cyc();
        bus.dmem_resp = 1'b0;
        @(negedge clk);
        if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL flw_ready: got %b want 1", bus.ex_ready); end n_tests++;
        // Flush during issue: mask still goes out, response still swallowed.
        cyc();
        drive_op(1'b1, 3'd2, 32'h4000, 32'h7777_8888);
        cyc();
        bus.ex_valid = 1'b0;
        bus.flush    = 1'b1;
        @(negedge clk);
        if (bus.dmem_wmask !== 4'b1111) begin n_fail++; $display("FAIL fli_mask: got %b want 1111", bus.dmem_wmask); end n_tests++;
        cyc();
        bus.flush     = 1'b0;
        bus.dmem_resp = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL fli_resp: valid %b want 0", bus.rsp_valid); end n_tests++;
        cyc();
        bus.dmem_resp = 1'b0;
        // Flush in HOLD: response vanishes immediately.
        drive_op(1'b0, 3'd0, 32'h5001, 32'h0);
        cyc();
        bus.ex_valid = 1'b0;
        cyc();
        bus.dmem_resp = 1'b1;
        bus.mem_stall = 1'b1;
        cyc();
        bus.dmem_resp = 1'b0;
        bus.flush     = 1'b1;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL flh_valid: got %b want 0", bus.rsp_valid); end n_tests++;
        cyc();
        bus.flush     = 1'b0;
        bus.mem_stall = 1'b0;
        @(negedge clk);
        if (bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL flh_ready: got %b want 1", bus.ex_ready); end n_tests++;
        cyc();
        test_load_word();
    endtask

    task automatic test_reset_mid();
        cyc();
        drive_op(1'b1, 3'd1, 32'h6002, 32'h0000_BEEF);
        cyc();
        bus.ex_valid = 1'b0;
        cyc();
        rst = 1'b1;
        cyc();
        rst            = 1'b0;
        bus.dmem_resp  = 1'b1;
        bus.dmem_rdata = 32'h9999_9999;
        @(negedge clk);
        if (bus.rsp_valid !== 1'b0 || bus.ex_ready !== 1'b1 || bus.bad_req !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl: valid %b ready %b bad %b want 0/1/0", bus.rsp_valid, bus.ex_ready, bus.bad_req); end n_tests++;
        if ({bus.dmem_addr, bus.dmem_wdata, bus.rsp_rdata} !== 96'h0 || {bus.dmem_rmask, bus.dmem_wmask, bus.rsp_shift, bus.rsp_is_load} !== 11'h0) begin n_fail++; $display("FAIL rstmid_data: addr %h wdata %h rdata %h masks %b%b", bus.dmem_addr, bus.dmem_wdata, bus.rsp_rdata, bus.dmem_rmask, bus.dmem_wmask); end n_tests++;
        cyc();
        bus.dmem_resp = 1'b0;
    endtask

    task automatic test_random();
        logic        st;
        logic [2:0]  f3;
        logic [31:0] a, wd, rd, exp_wd;
        logic [3:0]  exp_m;
        bit          legal;
        int          lat, k;
        for (int n = 0; n < 120; n++) begin
            st = 1'($urandom_range(0, 1));
            f3 = 3'($urandom_range(0, 7));
            a  = $urandom;
            wd = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 2) == 0) f3 = 3'd0;
            legal  = m_legal(st, f3, a);
            exp_m  = m_mask(f3, a);
            exp_wd = st ? m_wdata(f3, wd) : 32'h0;
            drive_op(st, f3, a, wd);
            @(negedge clk);
            if (bus.bad_req !== !legal || bus.ex_ready !== 1'b1) begin n_fail++; $display("FAIL rnd_accept: op %0d st %b f3 %0d addr %h bad %b want %b", n, st, f3, a, bus.bad_req, !legal); end n_tests++;
            cyc();
            bus.ex_valid = 1'b0;
            if (!legal) begin
                @(negedge clk);
                if (bus.ex_ready !== 1'b1 || {bus.dmem_rmask, bus.dmem_wmask} !== 8'h00) begin n_fail++; $display("FAIL rnd_reject: op %0d ready %b masks %b%b want 1/0", n, bus.ex_ready, bus.dmem_rmask, bus.dmem_wmask); end n_tests++;
                cyc();
            end else begin
                @(negedge clk);
                if (bus.dmem_addr !== (a & 32'hFFFF_FFFC) || bus.dmem_rmask !== (st ? 4'h0 : exp_m) || bus.dmem_wmask !== (st ? exp_m : 4'h0)) begin n_fail++; $display("FAIL rnd_issue: op %0d addr %h r %b w %b want %h r %b w %b", n, bus.dmem_addr, bus.dmem_rmask, bus.dmem_wmask, a & 32'hFFFF_FFFC, st ? 4'h0 : exp_m, st ? exp_m : 4'h0); end n_tests++;
                if (bus.dmem_wdata !== exp_wd || bus.rsp_shift !== 2'(a % 4) || bus.rsp_is_load !== !st) begin n_fail++; $display("FAIL rnd_issue_data: op %0d wdata %h shift %0d load %b want %h %0d %b", n, bus.dmem_wdata, bus.rsp_shift, bus.rsp_is_load, exp_wd, a % 4, !st); end n_tests++;
                cyc();
                lat = $urandom_range(0, 3);
                for (int i = 0; i < lat; i++) begin
                    @(negedge clk);
                    if ({bus.dmem_rmask, bus.dmem_wmask} !== 8'h00 || bus.rsp_valid !== 1'b0 || bus.dmem_wdata !== exp_wd) begin n_fail++; $display("FAIL rnd_wait: op %0d masks %b%b valid %b wdata %h want 0/0/%h", n, bus.dmem_rmask, bus.dmem_wmask, bus.rsp_valid, bus.dmem_wdata, exp_wd); end n_tests++;
                    cyc();
                end
                k  = $urandom_range(0, 3);
                rd = $urandom;
                exp_q.push_back(rd);
                bus.dmem_resp  = 1'b1;
                bus.dmem_rdata = rd;
                bus.mem_stall  = (k > 0);
                for (int i = 0; i <= k; i++) begin
                    @(negedge clk);
                    if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp_q[0] || bus.rsp_is_load !== !st || bus.rsp_shift !== 2'(a % 4)) begin n_fail++; $display("FAIL rnd_rsp: op %0d cyc %0d valid %b rdata %h want %h load %b shift %0d", n, i, bus.rsp_valid, bus.rsp_rdata, exp_q[0], bus.rsp_is_load, bus.rsp_shift); end n_tests++;
                    cyc();
                    bus.dmem_resp  = 1'b0;
                    bus.dmem_rdata = $urandom;
                    bus.mem_stall  = (i + 1 < k);
                end
                void'(exp_q.pop_front());
                bus.mem_stall = 1'b0;
                @(negedge clk);
                if (bus.ex_ready !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.dmem_wdata !== 32'h0) begin n_fail++; $display("FAIL rnd_done: op %0d ready %b valid %b wdata %h want 1/0/0", n, bus.ex_ready, bus.rsp_valid, bus.dmem_wdata); end n_tests++;
                cyc();
            end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_stall_hold();
        test_bad_req();
        test_flush();
        test_reset_mid();
        test_random();
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d entries want 0", exp_q.size()); end n_tests++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
